ram_board: RTL and testbench

RAM_BOARD -- requirements
Module: ram_board

---
 rtl/ram_board_pkg.sv | 39 +++
 rtl/ram_board_board_judge.sv | 48 ++++
 rtl/ram_board.sv | 73 +++++++
 tb/tb_ram_board.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ram_board_pkg.sv
// ram_board_pkg
// Shared definitions for the ultimate tic-tac-toe board RAM: cell and
// macro-board state encodings, address width and the table of the eight
// winning lines of a 3x3 board.
// No ports (package).
package ram_board_pkg;

    localparam int ADDR_W = 4;

    // Value written on the data bus that is never stored.
    localparam logic [1:0] CELL_RESERVED = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IN_PROGRESS = 2'b00,
        P1_WIN      = 2'b01,
        P2_WIN      = 2'b10,
        TIE         = 2'b11
    } board_state_t;

    // Zero-based cell indices (row-major) of every line that wins a board:
    // three rows, three columns, then the two diagonals.
    localparam int unsigned LINE_TABLE [8][3] = '{
        '{0, 1, 2},
        '{3, 4, 5},
        '{6, 7, 8},
        '{0, 3, 6},
        '{1, 4, 7},
        '{2, 5, 8},
        '{0, 4, 8},
        '{2, 4, 6}
    };

endpackage

// File: rtl/ram_board_board_judge.sv
// board_judge
// Purely combinational evaluation of one 3x3 board.
// Ports:
//   cells  in  18  nine 2-bit cells, cell i (zero-based, row-major) at [2i+1:2i]
//   state  out 2   IN_PROGRESS / P1_WIN / P2_WIN / TIE
module board_judge
    import ram_board_pkg::*;
(
    input  logic [17:0] cells,
    output logic [1:0]  state
);

    logic p1_line;
    logic p2_line;
    logic full;

    // Player 1 is tested first so that a board holding lines for both
    // players reports a player 1 win; a win always beats a full board.
    always_comb begin
        p1_line = 1'b0;
        p2_line = 1'b0;
        full    = 1'b1;
        for (int l = 0; l < 8; l++) begin
            if (cells[2*LINE_TABLE[l][0] +: 2] == P1 &&
                cells[2*LINE_TABLE[l][1] +: 2] == P1 &&
                cells[2*LINE_TABLE[l][2] +: 2] == P1)
                p1_line = 1'b1;
            if (cells[2*LINE_TABLE[l][0] +: 2] == P2 &&
                cells[2*LINE_TABLE[l][1] +: 2] == P2 &&
                cells[2*LINE_TABLE[l][2] +: 2] == P2)
                p2_line = 1'b1;
        end
        for (int i = 0; i < 9; i++) begin
            if (cells[2*i +: 2] == EMPTY)
                full = 1'b0;
        end

        if (p1_line)
            state = P1_WIN;
        else if (p2_line)
            state = P2_WIN;
        else if (full)
            state = TIE;
        else
            state = IN_PROGRESS;
    end

endmodule

// File: rtl/ram_board.sv
// ram_board
// 81-cell storage for an ultimate tic-tac-toe game (9 macro boards of 9
// cells, 2 bits each) with combinational read-out of the addressed cell
// and of the addressed macro board's game state.
// Ports:
//   clk         in  1  clock, all updates on rising edge
//   reset       in  1  synchronous active-high clear of all cells
//   we          in  1  write enable
//   data        in  2  cell value to write (11 is never stored)
//   addr_macro  in  4  macro board 1..9
//   addr_micro  in  4  cell inside macro board 1..9
//   q           out 2  addressed cell content (00 for invalid address)
//   state       out 2  addressed macro board state (00 for invalid address)
// Configuration macro: RAM_BOARD_WRITE_PROTECT_EN -- when defined, writes
// to an occupied cell or to a board that is already decided are dropped.
module ram_board
    import ram_board_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        data,
    input  logic [ADDR_W-1:0] addr_macro,
    input  logic [ADDR_W-1:0] addr_micro,
    output logic [1:0]        q,
    output logic [1:0]        state
);

    logic [17:0]       board_mem [9];
    logic              macro_ok;
    logic              micro_ok;
    logic [ADDR_W-1:0] macro_idx;
    logic [ADDR_W-1:0] micro_idx;
    logic [17:0]       sel_board;
    logic [1:0]        board_state;
    logic              write_ok;

    assign macro_ok  = (addr_macro >= 4'd1) && (addr_macro <= 4'd9);
    assign micro_ok  = (addr_micro >= 4'd1) && (addr_micro <= 4'd9);
    assign macro_idx = addr_macro - 4'd1;
    assign micro_idx = addr_micro - 4'd1;

    // An invalid macro address presents an all-empty board to the judge,
    // which naturally yields IN_PROGRESS.
    assign sel_board = macro_ok ? board_mem[macro_idx] : 18'd0;

    board_judge u_judge (
        .cells (sel_board),
        .state (board_state)
    );

    assign state = board_state;
    assign q     = (macro_ok && micro_ok) ? sel_board[{micro_idx, 1'b0} +: 2] : 2'b00;

`ifdef RAM_BOARD_WRITE_PROTECT_EN
    // Only an empty cell on an undecided board may be claimed.
    assign write_ok = we && macro_ok && micro_ok && (data != CELL_RESERVED) &&
                      (q == EMPTY) && (board_state == IN_PROGRESS);
`else
    assign write_ok = we && macro_ok && micro_ok && (data != CELL_RESERVED);
`endif

    // Reset wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 9; b++)
                board_mem[b] <= '0;
        end else if (write_ok) begin
            board_mem[macro_idx][{micro_idx, 1'b0} +: 2] <= data;
        end
    end

endmodule

// File: tb/tb_ram_board.sv
// tb_ram_board
// Directed self-checking bench for ram_board with hand-computed expected
// values for cell read-back and macro board state.
module tb_ram_board;

    logic       clk;
    logic       reset;
    logic       we;
    logic [1:0] data;
    logic [3:0] addr_macro;
    logic [3:0] addr_micro;
    logic [1:0] q;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    ram_board dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .data       (data),
        .addr_macro (addr_macro),
        .addr_micro (addr_micro),
        .q          (q),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [1:0] actual, input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // One write cycle: inputs change on the falling edge, take effect on the
    // next rising edge.
    task automatic applyStimulus(input logic [3:0] m, input logic [3:0] u, input logic [1:0] d);
        @(negedge clk);
        we         = 1'b1;
        data       = d;
        addr_macro = m;
        addr_micro = u;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic probeCell(input string tag, input logic [3:0] m, input logic [3:0] u, input logic [1:0] exp_q);
        @(negedge clk);
        addr_macro = m;
        addr_micro = u;
        #1;
        checkOutput(tag, q, exp_q);
    endtask

    task automatic probeState(input string tag, input logic [3:0] m, input logic [1:0] exp_s);
        @(negedge clk);
        addr_macro = m;
        addr_micro = 4'd1;
        #1;
        checkOutput(tag, state, exp_s);
    endtask

    logic [1:0] tie_vals [9] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [1:0] ovr_exp;

    initial begin
        reset      = 1'b1;
        we         = 1'b0;
        data       = 2'b00;
        addr_macro = 4'd1;
        addr_micro = 4'd1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        probeCell("reset_q_1_1", 4'd1, 4'd1, 2'b00);
        probeCell("reset_q_9_9", 4'd9, 4'd9, 2'b00);
        probeState("reset_state_1", 4'd1, 2'b00);

        // Tie on board 2: state stays 00 until the last cell fills it.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'd2, 4'(i + 1), tie_vals[i]);
            checkOutput($sformatf("tie_state_after_%0d", i + 1), state, (i == 8) ? 2'b11 : 2'b00);
        end
        probeCell("tie_q_2_3", 4'd2, 4'd3, 2'b10);

        // Row win on board 5.
        applyStimulus(4'd5, 4'd1, 2'b01);
        applyStimulus(4'd5, 4'd2, 2'b01);
        checkOutput("row_two_of_three", state, 2'b00);
        applyStimulus(4'd5, 4'd3, 2'b01);
        checkOutput("row_win_state_5", state, 2'b01);
        probeState("row_state_4", 4'd4, 2'b00);

        // Diagonal win for player 2 on board 9.
        applyStimulus(4'd9, 4'd3, 2'b10);
        applyStimulus(4'd9, 4'd5, 2'b10);
        applyStimulus(4'd9, 4'd7, 2'b10);
        checkOutput("diag_state_9", state, 2'b10);
        probeCell("diag_q_9_5", 4'd9, 4'd5, 2'b10);

        // Invalid addresses and reserved data are dropped.
        applyStimulus(4'd0, 4'd1, 2'b01);
        applyStimulus(4'd1, 4'd12, 2'b01);
        applyStimulus(4'd10, 4'd1, 2'b01);
        applyStimulus(4'd3, 4'd1, 2'b11);
        probeCell("inv_q_1_1", 4'd1, 4'd1, 2'b00);
        probeState("inv_state_1", 4'd1, 2'b00);
        probeCell("inv_q_3_1", 4'd3, 4'd1, 2'b00);
        probeCell("inv_q_addr0", 4'd0, 4'd1, 2'b00);
        probeState("inv_state_addr0", 4'd0, 2'b00);
        probeCell("inv_q_micro12", 4'd2, 4'd12, 2'b00);

        // Both players hold a line: player 1 wins.
        applyStimulus(4'd6, 4'd4, 2'b10);
        applyStimulus(4'd6, 4'd5, 2'b10);
        applyStimulus(4'd6, 4'd6, 2'b10);
        checkOutput("prio_p2_only", state, 2'b10);
        applyStimulus(4'd6, 4'd1, 2'b01);
        applyStimulus(4'd6, 4'd2, 2'b01);
        applyStimulus(4'd6, 4'd3, 2'b01);
`ifdef RAM_BOARD_WRITE_PROTECT_EN
        checkOutput("prio_state_6", state, 2'b10);
`else
        checkOutput("prio_state_6", state, 2'b01);
`endif

        // Full board with a player 1 row reports the win, not a tie.
        applyStimulus(4'd8, 4'd4, 2'b10);
        applyStimulus(4'd8, 4'd5, 2'b10);
        applyStimulus(4'd8, 4'd6, 2'b01);
        applyStimulus(4'd8, 4'd7, 2'b10);
        applyStimulus(4'd8, 4'd8, 2'b01);
        applyStimulus(4'd8, 4'd9, 2'b10);
        applyStimulus(4'd8, 4'd1, 2'b01);
        applyStimulus(4'd8, 4'd2, 2'b01);
        applyStimulus(4'd8, 4'd3, 2'b01);
        checkOutput("full_win_state_8", state, 2'b01);

        // Holding a write for several cycles.
        @(negedge clk);
        we = 1'b1; data = 2'b10; addr_macro = 4'd4; addr_micro = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        we = 1'b0;
        checkOutput("hold_q_4_5", q, 2'b10);
        checkOutput("hold_state_4", state, 2'b00);

        // Other boards untouched.
        probeState("indep_state_2", 4'd2, 2'b11);
        probeState("indep_state_5", 4'd5, 2'b01);
        probeCell("indep_q_5_4", 4'd5, 4'd4, 2'b00);

        // Overwrite behaviour.
        applyStimulus(4'd1, 4'd1, 2'b01);
        applyStimulus(4'd1, 4'd1, 2'b10);
`ifdef RAM_BOARD_WRITE_PROTECT_EN
        ovr_exp = 2'b01;
`else
        ovr_exp = 2'b10;
`endif
        checkOutput("overwrite_q_1_1", q, ovr_exp);

        // Reset with a simultaneous write.
        @(negedge clk);
        reset = 1'b1; we = 1'b1; data = 2'b01; addr_macro = 4'd3; addr_micro = 4'd3;
        @(posedge clk);
        #1;
        reset = 1'b0; we = 1'b0;
        probeCell("rst_q_3_3", 4'd3, 4'd3, 2'b00);
        probeCell("rst_q_2_5", 4'd2, 4'd5, 2'b00);
        probeState("rst_state_2", 4'd2, 2'b00);
        probeState("rst_state_5", 4'd5, 2'b00);
        probeState("rst_state_9", 4'd9, 2'b00);
        probeCell("rst_q_1_1", 4'd1, 4'd1, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
